// File: rtl/core_v_mini_mcu_pkg.sv
// ============================================================================
// Module      : core_v_mini_mcu_pkg
// Description : MCU-level constants used by the CPU-side bus blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_v_mini_mcu_pkg;

    // Granted-but-unanswered core transactions the CPU OBI slice may hold.
    localparam int unsigned OBI_SLICE_MAX_OUTSTANDING = 2;

endpackage

`default_nettype wire

// File: rtl/obi_pkg.sv
// ============================================================================
// Module      : obi_pkg
// Description : OBI request/response structures shared by bus-side blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

`default_nettype wire

// File: rtl/cpu_obi_slice.sv
// ============================================================================
// Module      : cpu_obi_slice
// Description : One-entry registered OBI request slice between the CPU data
//               port and the bus, with an outstanding-transaction limiter.
//               Define CPU_OBI_SLICE_RESP_REG_EN to register the response path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_obi_slice
    import obi_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = core_v_mini_mcu_pkg::OBI_SLICE_MAX_OUTSTANDING
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  core_req_i,
    output obi_resp_t core_resp_o,
    output obi_req_t  bus_req_o,
    input  obi_resp_t bus_resp_i
);

    localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    obi_req_t         slot;
    logic [CNT_W-1:0] count;
    logic             grant;
    logic             resp_valid;
    logic [31:0]      resp_data;
    logic             core_rvalid;

    // The slot may be refilled in the same cycle the bus takes its current entry.
    assign grant = rst_ni && core_req_i.req && (count < CNT_MAX)
                   && (!slot.req || bus_resp_i.gnt);

    // slot.req doubles as the slot valid bit and drives bus_req_o.req directly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot <= '0;
        end else if (grant) begin
            slot <= core_req_i;
        end else if (bus_resp_i.gnt) begin
            slot.req <= 1'b0;
        end
    end

`ifdef CPU_OBI_SLICE_RESP_REG_EN
    logic        resp_valid_q;
    logic [31:0] resp_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= bus_resp_i.rvalid;
            resp_data_q  <= bus_resp_i.rdata;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
`else
    assign resp_valid = bus_resp_i.rvalid;
    assign resp_data  = bus_resp_i.rdata;
`endif

    // With nothing outstanding a response can only be a leftover from before reset.
    assign core_rvalid = rst_ni && resp_valid && (count != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (grant && !core_rvalid) begin
            count <= count + CNT_W'(1);
        end else if (!grant && core_rvalid) begin
            count <= count - CNT_W'(1);
        end
    end

    always_comb begin
        core_resp_o        = '0;
        core_resp_o.gnt    = grant;
        core_resp_o.rvalid = core_rvalid;
        core_resp_o.rdata  = core_rvalid ? resp_data : '0;
    end

    assign bus_req_o = slot;

endmodule

`default_nettype wire

// File: doc/cpu_obi_slice.md
CPU_OBI_SLICE -- requirements
Module: cpu_obi_slice

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of core transactions granted but not yet answered (legal range 1..15).
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_ni, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port core_req_i, input, obi_req_t, the OBI request from the CPU subsystem data port.
REQ-005 SHALL have port core_resp_o, output, obi_resp_t, the OBI grant, rvalid and rdata returned to the CPU subsystem.
REQ-006 SHALL have port bus_req_o, output, obi_req_t, the registered OBI request to the bus/crossbar.
REQ-007 SHALL have port bus_resp_i, input, obi_resp_t, the OBI response from the bus/crossbar.

Function
REQ-008 SHALL hold a one-entry request slot (valid bit plus addr, we, be, wdata).
REQ-009 SHALL count outstanding transactions with a counter: +1 on core handshake (core_req_i.req && core_resp_o.gnt), -1 on core_resp_o.rvalid, unchanged when both occur in one cycle.
REQ-010 SHALL assert core_resp_o.gnt only when core_req_i.req=1, count < MAX_OUTSTANDING, and the slot is empty or is being drained this cycle (bus_resp_i.gnt=1).
REQ-011 SHALL load the slot on core handshake.
REQ-012 SHALL present the slot on the bus one cycle after the core handshake.
REQ-013 SHALL drive bus_req_o.req = slot valid.
REQ-014 SHALL clear the slot on bus grant unless a new core handshake reloads it in the same cycle (back-to-back, 1 request/cycle throughput).
REQ-015 SHALL keep bus_req_o payload stable while bus_req_o.req=1 and bus_resp_i.gnt=0 (OBI hold rule).
REQ-016 SHALL NOT apply backpressure on rvalid; MAX_OUTSTANDING bounds in-flight responses.
REQ-017 SHALL NOT drop, duplicate or reorder responses.
REQ-018 SHALL generate core_resp_o.gnt combinationally from core_req_i.req, counter, slot state and bus_resp_i.gnt, with no other combinational path from bus_req_o.
REQ-019 SHALL stall the core with gnt=0 at count == MAX_OUTSTANDING until an rvalid is delivered; an rvalid in that cycle re-enables gnt in the next cycle.

Reset
REQ-020 SHALL, while rst_ni=0, force slot valid=0, counter=0, bus_req_o all-zero, and core_resp_o.gnt/rvalid=0, rdata=0.
REQ-021 SHALL, on reset mid-transaction, discard the slot and counter; any late bus rvalid after reset SHALL be ignored (not forwarded, counter not decremented below 0).

Configuration
REQ-022 SHALL, with CPU_OBI_SLICE_RESP_REG_EN defined, register bus_resp_i.rvalid/rdata, giving 1 extra cycle of response latency (core rvalid one cycle after bus rvalid).
REQ-023 SHALL, without CPU_OBI_SLICE_RESP_REG_EN, pass rvalid/rdata combinationally from bus_resp_i to core_resp_o with zero added latency.
REQ-024 SHALL base the counter decrement (REQ-009) on the core-side rvalid in both configurations.

Structure
REQ-025 SHALL reuse obi_req_t/obi_resp_t from obi_pkg.
REQ-026 SHALL define the default outstanding-count constant OBI_SLICE_MAX_OUTSTANDING in core_v_mini_mcu_pkg.
REQ-027 SHALL be a single module with no sub-module; the counter width SHALL be $clog2(MAX_OUTSTANDING+1).

Verification
REQ-028 SHALL cover: single read, addr 0x2000_0010, bus gnt immediate, rvalid 2 cycles later with rdata 0xDEAD_BEEF -> bus req 1 cycle after core gnt; core rvalid with 0xDEAD_BEEF after 0 (macro off) / 1 (macro on) extra cycles.
REQ-029 SHALL cover: bus gnt held 0 for 5 cycles on a write with wdata 0x1234_5678, be 4'b0011 -> bus_req_o payload unchanged for all 5 cycles; core gnt=0 for a second request until the bus grants.
REQ-030 SHALL cover: back-to-back 4 reads with bus gnt=1 every cycle, MAX_OUTSTANDING=2, rvalid 3 cycles after each bus gnt -> core gnt stalls at count=2; all 4 responses delivered in order; counter returns to 0.
REQ-031 SHALL cover: core handshake and core rvalid in the same cycle at count=1 -> counter stays 1.
REQ-032 SHALL cover: rst_ni asserted while slot valid and count=2 -> outputs zero immediately; after release, a following read completes normally with counter starting at 0.
